// File: rtl/pwm_axil_bridge_if.sv
// Purpose : bundles the AXI4-Lite slave channels and the register-file strobe port
//           of the PWM register bridge into one interface.
// Ports   : slave modport = bridge view (drives readies, responses, strobes; reads
//           AXI requests and read_data); master modport = host + register-file view.
interface pwm_axil_bridge_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 7,
    parameter int REG_ADDR_WIDTH = 5
);
    // write address / data / response channels
    logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
    logic                      s_awvalid;
    logic                      s_awready;
    logic [DATA_WIDTH-1:0]     s_wdata;
    logic [DATA_WIDTH/8-1:0]   s_wstrb;
    logic                      s_wvalid;
    logic                      s_wready;
    logic [1:0]                s_bresp;
    logic                      s_bvalid;
    logic                      s_bready;
    // read address / data channels
    logic [AXI_ADDR_WIDTH-1:0] s_araddr;
    logic                      s_arvalid;
    logic                      s_arready;
    logic [DATA_WIDTH-1:0]     s_rdata;
    logic [1:0]                s_rresp;
    logic                      s_rvalid;
    logic                      s_rready;
    // register-file port
    logic                      write_en;
    logic [REG_ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0]     write_data;
    logic                      read_en;
    logic [REG_ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0]     read_data;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready, read_data,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid,
        output write_en, write_addr, write_data, read_en, read_addr
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready, read_data,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid,
        input  write_en, write_addr, write_data, read_en, read_addr
    );
endinterface

// File: rtl/pwm_axil_bridge.sv
// Purpose : AXI4-Lite slave turning host writes/reads into one-cycle write_en/read_en
//           strobes on the PWM register-file port (read data returns 1 cycle after read_en).
// Ports   : clk, rst (sync, active-high), bus (pwm_axil_bridge_if.slave). Latency: AW+W -> write_en
//           next cycle -> bvalid after; AR -> read_en next cycle -> rvalid two cycles later.
//           Backpressure: bready/rready low stall only their own channel; all outputs registered.
module pwm_axil_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 7,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 9
) (
    input  logic                clk,
    input  logic                rst,
    pwm_axil_bridge_if.slave    bus
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [REG_ADDR_WIDTH-1:0] NUM_REGS_W = REG_ADDR_WIDTH'(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_WAIT, R_RESP} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                      aw_ok_q, aw_ok_d, strb_ok_q, strb_ok_d;
    logic                      awready_q, awready_d, wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      write_en_q, write_en_d;
    logic [REG_ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;

    logic                      ar_pend_q, ar_pend_d, rd_ok_q, rd_ok_d;
    logic                      arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      read_en_q, read_en_d;
    logic [REG_ADDR_WIDTH-1:0] read_addr_q, read_addr_d;

    // byte-lane bits of the addresses carry no information for word registers
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.s_awaddr[1:0], bus.s_araddr[1:0]};

    logic [REG_ADDR_WIDTH-1:0] aw_idx, ar_idx;
    logic                      aw_hs, w_hs, ar_hs;
    assign aw_idx = bus.s_awaddr[REG_ADDR_WIDTH+1:2];
    assign ar_idx = bus.s_araddr[REG_ADDR_WIDTH+1:2];
    assign aw_hs  = bus.s_awvalid & awready_q;
    assign w_hs   = bus.s_wvalid  & wready_q;
    assign ar_hs  = bus.s_arvalid & arready_q;

    // write FSM: the write_addr/write_data outputs double as the AW/W capture registers
    always_comb begin
        w_state_d    = w_state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        aw_ok_d      = aw_ok_q;
        strb_ok_d    = strb_ok_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        write_en_d   = 1'b0;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d    = 1'b1;
                    write_addr_d = aw_idx;
                    aw_ok_d      = (aw_idx < NUM_REGS_W);
                end
                if (w_hs) begin
                    w_held_d     = 1'b1;
                    write_data_d = bus.s_wdata;
                    strb_ok_d    = &bus.s_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d  = W_EXEC;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    write_en_d = aw_ok_d && strb_ok_d;
                    bresp_d    = (aw_ok_d && strb_ok_d) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_EXEC: begin
                w_state_d = W_RESP;
                bvalid_d  = 1'b1;
            end
            W_RESP: begin
                if (bus.s_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // read FSM: an accepted AR waits in R_IDLE (ar_pend) for one cycle if the write
    // strobe would otherwise coincide, so writes always win and reads see fresh data
    always_comb begin
        r_state_d   = r_state_q;
        ar_pend_d   = ar_pend_q;
        rd_ok_d     = rd_ok_q;
        read_addr_d = read_addr_q;
        read_en_d   = 1'b0;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_pend_d   = 1'b1;
                    read_addr_d = ar_idx;
                    rd_ok_d     = (ar_idx < NUM_REGS_W);
                end
                if (ar_pend_d && (w_state_d != W_EXEC)) begin
                    r_state_d = R_EXEC;
                    ar_pend_d = 1'b0;
                    read_en_d = rd_ok_d;
                end
            end
            R_EXEC: r_state_d = R_WAIT;
            R_WAIT: begin
                rdata_d   = rd_ok_q ? bus.read_data : '0;
                rresp_d   = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
                rvalid_d  = 1'b1;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (bus.s_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE) && !ar_pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q    <= W_IDLE;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            aw_ok_q      <= 1'b0;
            strb_ok_q    <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            r_state_q    <= R_IDLE;
            ar_pend_q    <= 1'b0;
            rd_ok_q      <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            read_en_q    <= 1'b0;
            read_addr_q  <= '0;
        end else begin
            w_state_q    <= w_state_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            aw_ok_q      <= aw_ok_d;
            strb_ok_q    <= strb_ok_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            r_state_q    <= r_state_d;
            ar_pend_q    <= ar_pend_d;
            rd_ok_q      <= rd_ok_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            read_en_q    <= read_en_d;
            read_addr_q  <= read_addr_d;
        end
    end

    assign bus.s_awready  = awready_q;
    assign bus.s_wready   = wready_q;
    assign bus.s_bvalid   = bvalid_q;
    assign bus.s_bresp    = bresp_q;
    assign bus.s_arready  = arready_q;
    assign bus.s_rvalid   = rvalid_q;
    assign bus.s_rresp    = rresp_q;
    assign bus.s_rdata    = rdata_q;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.read_en    = read_en_q;
    assign bus.read_addr  = read_addr_q;
endmodule

// File: tb/tb_pwm_axil_bridge.sv
// Purpose : directed self-checking bench for pwm_axil_bridge with a simple register-file
//           stand-in (write on write_en, read_data registered one cycle after read_en).
// Ports   : none; drives the interface master side, samples 1 time unit after each rising edge.
module tb_pwm_axil_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_axil_bridge_if #(.DATA_WIDTH(32), .AXI_ADDR_WIDTH(7), .REG_ADDR_WIDTH(5)) bus ();

    pwm_axil_bridge #(
        .DATA_WIDTH(32), .AXI_ADDR_WIDTH(7), .REG_ADDR_WIDTH(5), .NUM_REGS(9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // register-file stand-in
    logic [31:0] regs [0:31];
    int          both_cnt;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            bus.read_data <= 32'd0;
        end else begin
            if (bus.write_en) regs[bus.write_addr] <= bus.write_data;
            if (bus.read_en)  bus.read_data <= regs[bus.read_addr];
        end
    end
    always @(posedge clk) begin
        if (rst) both_cnt <= 0;
        else if (bus.write_en && bus.read_en) both_cnt <= both_cnt + 1;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed so far)", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata = '0; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b1;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b1;

        // ---- reset state
        tick(); tick();
        check("rst_awready", bus.s_awready, 0);
        check("rst_wready",  bus.s_wready,  0);
        check("rst_arready", bus.s_arready, 0);
        check("rst_bvalid",  bus.s_bvalid,  0);
        check("rst_rvalid",  bus.s_rvalid,  0);
        check("rst_strobes", {bus.write_en, bus.read_en}, 0);
        check("rst_resp",    {bus.s_bresp, bus.s_rresp}, 0);
        check("rst_rdata",   bus.s_rdata, 0);
        rst = 1'b0;
        tick();
        check("post_rst_readies", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);

        // ---- AW+W together: write 123 to index 0
        bus.s_awaddr = 7'h00; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'd123; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("w0_write_en",   bus.write_en,   1);
        check("w0_write_addr", bus.write_addr, 0);
        check("w0_write_data", bus.write_data, 123);
        check("w0_awready_lo", bus.s_awready,  0);
        check("w0_bvalid_early", bus.s_bvalid, 0);
        tick();
        check("w0_write_en_1cyc", bus.write_en, 0);
        check("w0_bvalid", bus.s_bvalid, 1);
        check("w0_bresp",  bus.s_bresp,  2'b00);
        tick();
        check("w0_bvalid_done", bus.s_bvalid, 0);
        check("w0_awready_back", bus.s_awready, 1);

        // ---- W first, AW three cycles later: 1000 -> index 1
        bus.s_wdata = 32'd1000; bus.s_wvalid = 1'b1;
        tick();
        bus.s_wvalid = 1'b0;
        check("w1_wready_lo", bus.s_wready, 0);
        check("w1_awready_hi", bus.s_awready, 1);
        check("w1_no_strobe", bus.write_en, 0);
        tick(); tick();
        bus.s_awaddr = 7'h04; bus.s_awvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
        check("w1_write_en",   bus.write_en,   1);
        check("w1_write_addr", bus.write_addr, 1);
        check("w1_write_data", bus.write_data, 1000);
        tick(); tick();
        // 500 -> index 2
        bus.s_awaddr = 7'h08; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'd500; bus.s_wvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("w2_write_addr", bus.write_addr, 2);
        check("w2_write_en",   bus.write_en,   1);
        tick(); tick();

        // ---- read back 0x04 and 0x08
        bus.s_araddr = 7'h04; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        check("r1_read_en",   bus.read_en,   1);
        check("r1_read_addr", bus.read_addr, 1);
        check("r1_arready_lo", bus.s_arready, 0);
        tick();
        check("r1_rvalid_early", bus.s_rvalid, 0);
        tick();
        check("r1_rvalid", bus.s_rvalid, 1);
        check("r1_rdata",  bus.s_rdata,  1000);
        check("r1_rresp",  bus.s_rresp,  2'b00);
        tick();
        check("r1_rvalid_done", bus.s_rvalid, 0);
        bus.s_araddr = 7'h08; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        check("r2_read_addr", bus.read_addr, 2);
        tick(); tick();
        check("r2_rvalid", bus.s_rvalid, 1);
        check("r2_rdata",  bus.s_rdata,  500);
        tick();

        // ---- out-of-range write (index 9) and read (index 31)
        bus.s_awaddr = 7'h24; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'd7; bus.s_wvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("oor_w_no_strobe", bus.write_en, 0);
        tick();
        check("oor_bvalid", bus.s_bvalid, 1);
        check("oor_bresp",  bus.s_bresp,  2'b10);
        tick();
        bus.s_araddr = 7'h7C; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        check("oor_r_no_strobe", bus.read_en, 0);
        tick(); tick();
        check("oor_rvalid", bus.s_rvalid, 1);
        check("oor_rresp",  bus.s_rresp,  2'b10);
        check("oor_rdata",  bus.s_rdata,  0);
        tick();
        // partial strobe
        bus.s_awaddr = 7'h0C; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'd9; bus.s_wstrb = 4'h3; bus.s_wvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_wstrb = 4'hF;
        check("strb_no_strobe", bus.write_en, 0);
        tick();
        check("strb_bresp", bus.s_bresp, 2'b10);
        tick();

        // ---- AR collides with write strobe: 55 -> index 0, read index 0
        bus.s_awaddr = 7'h00; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'd55; bus.s_wvalid = 1'b1;
        bus.s_araddr = 7'h00; bus.s_arvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        check("col_write_en", bus.write_en, 1);
        check("col_read_held", bus.read_en, 0);
        tick();
        check("col_read_en", bus.read_en, 1);
        check("col_write_en_off", bus.write_en, 0);
        tick(); tick();
        check("col_rvalid", bus.s_rvalid, 1);
        check("col_rdata",  bus.s_rdata,  55);
        tick();

        // ---- B backpressure while a read runs: 77 -> index 4
        bus.s_bready = 1'b0;
        bus.s_awaddr = 7'h10; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'd77; bus.s_wvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        tick();
        check("bp_bvalid", bus.s_bvalid, 1);
        // next write offered and a read issued during the stall
        bus.s_awaddr = 7'h14; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'd88; bus.s_wvalid = 1'b1;
        bus.s_araddr = 7'h04; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        check("bp_read_en", bus.read_en, 1);
        check("bp_awready_lo", bus.s_awready, 0);
        tick(); tick();
        check("bp_rvalid", bus.s_rvalid, 1);
        check("bp_rdata",  bus.s_rdata,  1000);
        check("bp_bvalid_hold", bus.s_bvalid, 1);
        check("bp_bresp_hold",  bus.s_bresp,  2'b00);
        tick(); tick();
        check("bp_no_new_write", bus.write_en, 0);
        check("bp_bvalid_still", bus.s_bvalid, 1);
        bus.s_bready = 1'b1;
        tick();
        check("bp_b_done", bus.s_bvalid, 0);
        check("bp_awready_back", bus.s_awready, 1);
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("bp_next_write_en",   bus.write_en,   1);
        check("bp_next_write_addr", bus.write_addr, 5);
        check("bp_next_write_data", bus.write_data, 88);
        tick(); tick();

        // ---- reset during R_WAIT with rready low
        bus.s_rready = 1'b0;
        bus.s_araddr = 7'h08; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rvalid", bus.s_rvalid, 0);
        check("mid_rst_arready", bus.s_arready, 0);
        tick();
        check("mid_rst_readies", bus.s_arready, 1);
        tick(); tick();
        check("mid_rst_no_resp", bus.s_rvalid, 0);
        bus.s_rready = 1'b1;
        bus.s_araddr = 7'h14; bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        check("after_rst_read_en", bus.read_en, 1);
        tick(); tick();
        check("after_rst_rvalid", bus.s_rvalid, 1);
        // register stand-in was cleared by the reset, so index 5 reads back 0
        check("after_rst_rdata", bus.s_rdata, 0);
        tick();

        check("strobes_never_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pwm_axil_bridge.md
Name: pwm_axil_bridge

Overview:
AXI4-Lite slave front end for the PWM generator register file. It accepts AXI4-Lite write and read transactions from the host and converts them into single-cycle write_en/read_en strobes on the register-file port. Read data returns from the register file with a fixed 1-cycle latency. Sits between the SoC interconnect and the PWM register bank.

Parameters:
DATA_WIDTH, 32, AXI and register-port data width
AXI_ADDR_WIDTH, 7, AXI byte-address width
REG_ADDR_WIDTH, 5, register-port word-address width
NUM_REGS, 9, count of implemented word addresses (prescale + 2 per channel, 4 channels)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
s_awaddr  in  AXI_ADDR_WIDTH  write address (byte)
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  AXI_ADDR_WIDTH  read address (byte)
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
write_en  out  1  register write strobe, one cycle
write_addr  out  REG_ADDR_WIDTH  register word index
write_data  out  DATA_WIDTH  register write data
read_en  out  1  register read strobe, one cycle
read_addr  out  REG_ADDR_WIDTH  register word index
read_data  in  DATA_WIDTH  register data, valid the cycle after read_en

Behaviour:
- Reset (rst=1 at an edge): all outputs 0 — s_awready, s_wready, s_arready, s_bvalid, s_rvalid, write_en, read_en, all addr/data/resp outputs. Reset mid-transaction abandons it; no strobe or response is produced afterward. Readies go to 1 in the first cycle after rst deasserts.
- All outputs are registered. Word index = byte address bits [REG_ADDR_WIDTH+1:2]; bits [1:0] are ignored.
- Write FSM, states W_IDLE -> W_EXEC -> W_RESP -> W_IDLE:
  - W_IDLE: AW and W are captured independently in either order or together. s_awready=1 until AW is captured, then 0. s_wready behaves the same for W.
  - When both are held, go to W_EXEC.
  - W_EXEC (1 cycle): write_en=1 only if index < NUM_REGS and s_wstrb is all ones. Otherwise write_en stays 0 and bresp=SLVERR.
  - W_RESP: s_bvalid=1 with a stable bresp until the s_bvalid&s_bready edge, then W_IDLE. AW/W are not accepted while in W_EXEC or W_RESP.
  - Minimum latency: AW+W handshake at edge N -> write_en high cycle N+1 -> s_bvalid high cycle N+2. If s_bready is already high, back-to-back writes take 3 cycles each.
- Read FSM, states R_IDLE -> R_EXEC -> R_WAIT -> R_RESP -> R_IDLE:
  - R_IDLE: s_arready=1; the AR handshake latches the index.
  - R_EXEC: read_en=1 only if index < NUM_REGS.
  - R_WAIT: capture read_data into s_rdata, or 0 with SLVERR for an out-of-range index.
  - R_RESP: s_rvalid=1 with s_rdata/s_rresp stable until the s_rvalid&s_rready edge.
  - Minimum latency: AR handshake at edge N -> read_en cycle N+1 -> s_rvalid cycle N+3.
- Read/write ordering: the read FSM does not enter R_EXEC while the write FSM is in W_EXEC; it holds one extra cycle. If both become ready in the same cycle, the write strobe goes first. A read issued after a write completes always returns the new value.
- write_en and read_en are never high in the same cycle.
- Backpressure: holding s_bready or s_rready low stalls only that channel. The other FSM keeps operating.

Test Plan:
- After reset, write AW=0x00 and W=123 (wstrb=F) in the same cycle -> write_en high for exactly 1 cycle with write_addr=0, write_data=123; bvalid two cycles after the handshake with bresp=00.
- Write W first (1000), then AW=0x04 three cycles later; then write AW=0x08 with W=500 -> register index 1 = 1000 and index 2 = 500. Read 0x04 and 0x08 -> rdata 1000 and 500, rresp=00, rvalid 3 cycles after each AR.
- Write to 0x24 (index 9) and read from 0x7C -> no write_en and no read_en; bresp=10; rresp=10 with rdata=0. A write with wstrb=0x3 -> no write_en, bresp=10.
- Issue AR=0x00 in the same cycle the write to 0x00 (value 55) enters W_EXEC -> read_en is delayed one cycle and rdata=55.
- Hold bready=0 for 5 cycles during a write while a read runs -> read completes normally; bvalid and bresp stay stable; a new AW is not accepted until the B handshake.
- Assert rst while a read is in R_WAIT and rready=0 -> rvalid=0 at the next cycle and no response follows; a new read after reset succeeds.
